// File: rtl/store_unit.sv
// store_unit: execute/memory-stage store engine.
// Computes the effective address, checks alignment, builds byte-lane write
// data and enables, and issues one req/ack write to data memory.
// Optional build macro: STORE_TIMEOUT_EN adds a REQ watchdog that raises bus_err.
module store_unit #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            store_valid,
  output logic            store_ready,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [11:0]     imm,
  input  logic [2:0]      store_control,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ack,
  output logic            store_done,
  output logic            misaligned_exc,
  output logic            bus_err,
  output logic [XLEN-1:0] fault_addr
);

  // Store width encodings (funct3 of the S-type instruction)
  localparam logic [2:0] CTRL_SB = 3'b000;
  localparam logic [2:0] CTRL_SH = 3'b001;
  localparam logic [2:0] CTRL_SW = 3'b010;

  typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

  state_t                 state_q, state_d;
  logic [XLEN-1:0]        addr_q, addr_d;
  logic [XLEN-1:0]        wdata_q, wdata_d;
  logic [3:0]             be_q, be_d;
  logic [XLEN-1:0]        fault_addr_q, fault_addr_d;
  logic signed [XLEN-1:0] imm_sext;
  logic [XLEN-1:0]        ea;
  logic                   misaligned;
  logic                   known_ctrl;

`ifdef STORE_TIMEOUT_EN
  logic [7:0]             cnt_q, cnt_d;
  logic [XLEN-1:0]        ea_q, ea_d;
  logic                   bus_err_q, bus_err_d;
`endif

  // Byte enables for the addressed lanes of the word
  function automatic logic [3:0] lane_be(input logic [2:0] ctrl, input logic [1:0] ofs);
    case (ctrl)
      CTRL_SB: lane_be = 4'b0001 << ofs;
      CTRL_SH: lane_be = ofs[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Replicate the store data across every lane so any enabled lane sees it
  function automatic logic [XLEN-1:0] lane_wdata(input logic [2:0] ctrl, input logic [XLEN-1:0] data);
    case (ctrl)
      CTRL_SB: lane_wdata = {4{data[7:0]}};
      CTRL_SH: lane_wdata = {2{data[15:0]}};
      default: lane_wdata = data;
    endcase
  endfunction

  // Effective address and alignment decode (wraps modulo 2^XLEN)
  always_comb begin
    imm_sext   = {{(XLEN-12){imm[11]}}, imm};
    ea         = rs1_data + imm_sext;
    misaligned = ((store_control == CTRL_SH) && ea[0]) ||
                 ((store_control == CTRL_SW) && (ea[1:0] != 2'b00));
    known_ctrl = (store_control == CTRL_SB) || (store_control == CTRL_SH) ||
                 (store_control == CTRL_SW);
  end

  // Next-state logic and request/fault register updates
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    fault_addr_d = fault_addr_q;
`ifdef STORE_TIMEOUT_EN
    cnt_d        = cnt_q;
    ea_d         = ea_q;
    bus_err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (store_valid) begin
          if (misaligned) begin
            state_d      = FAULT;
            fault_addr_d = ea;
          end else if (!known_ctrl) begin
            state_d = DONE;
          end else begin
            state_d = REQ;
            addr_d  = {ea[XLEN-1:2], 2'b00};
            wdata_d = lane_wdata(store_control, rs2_data);
            be_d    = lane_be(store_control, ea[1:0]);
`ifdef STORE_TIMEOUT_EN
            cnt_d   = 8'd0;
            ea_d    = ea;
`endif
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = DONE;
          addr_d  = '0;
          wdata_d = '0;
          be_d    = '0;
`ifdef STORE_TIMEOUT_EN
        end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          // Count reaches the limit on this edge without an ack
          state_d      = IDLE;
          bus_err_d    = 1'b1;
          fault_addr_d = ea_q;
          addr_d       = '0;
          wdata_d      = '0;
          be_d         = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any outstanding request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      fault_addr_q <= fault_addr_d;
    end
  end

`ifdef STORE_TIMEOUT_EN
  // Watchdog counter, captured address and bus error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 8'd0;
      ea_q      <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ea_q      <= ea_d;
      bus_err_q <= bus_err_d;
    end
  end
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign store_ready    = (state_q == IDLE);
  assign mem_req        = (state_q == REQ);
  assign store_done     = (state_q == DONE);
  assign misaligned_exc = (state_q == FAULT);
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_be         = be_q;
  assign fault_addr     = fault_addr_q;

endmodule
